// File: rtl/part2_sweep_ctrl.sv
// Exhaustive 4-input truth-table sweeper with mismatch count and first-fail capture (optional resp_vec via SWEEP_CAPTURE_EN).
// Latency: start to done pulse is 16*(SETTLE+1)+1 cycles; busy is high from the cycle after start through FINISH.
// Backpressure: none; start is ignored while busy or when abort is coincident, and abort returns to IDLE next cycle.
`timescale 1ns/1ps
module part2_sweep_ctrl #(
    parameter logic [15:0] EXPECTED = 16'h28AC,
    parameter int          SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        out1_fb,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_fail
`ifdef SWEEP_CAPTURE_EN
    ,
    output logic [15:0] resp_vec
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] stim;
    logic       launch;
    logic       settled;
    logic       last_vec;
    logic       mismatch;

    assign launch   = (state == IDLE) && start && !abort;
    assign settled  = (settle_cnt == SETTLE_LAST);
    assign last_vec = (idx == 4'd15);
    assign mismatch = (out1_fb != EXPECTED[idx]);

    // stim is a dedicated register so the pins hold their value in IDLE/FINISH
    assign {in1, in2, in3, in4} = stim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (launch) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settled) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_vec) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = DRIVE;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            stim       <= 4'd0;
            err_cnt    <= 5'd0;
            first_fail <= 4'd0;
            pass       <= 1'b0;
`ifdef SWEEP_CAPTURE_EN
            resp_vec   <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        stim       <= 4'd0;
                        err_cnt    <= 5'd0;
                        pass       <= 1'b0;
`ifdef SWEEP_CAPTURE_EN
                        resp_vec   <= 16'd0;
`endif
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else if (!settled) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    // an abort here discards the pending compare so the counts hold
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + 5'd1;
                            if (err_cnt == 5'd0) begin
                                first_fail <= idx;
                            end
                        end
`ifdef SWEEP_CAPTURE_EN
                        resp_vec[idx] <= out1_fb;
`endif
                        if (!last_vec) begin
                            idx        <= idx + 4'd1;
                            stim       <= idx + 4'd1;
                            settle_cnt <= 4'd0;
                        end
                    end
                end
                FINISH: begin
                    pass <= (err_cnt == 5'd0);
                end
                default: begin
                    pass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_part2_sweep_ctrl.sv
// Bench for part2_sweep_ctrl: table of feedback patterns with expected results, scored through a queue,
// plus hand-written restart, coincident start/abort, abort and mid-sweep reset sequences.
`timescale 1ns/1ps
module tb_part2_sweep_ctrl;

    localparam int SETTLE = 2;
    localparam int LAT    = 16 * (SETTLE + 1) + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out1_fb;
    logic        in1, in2, in3, in4;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;
`ifdef SWEEP_CAPTURE_EN
    logic [15:0] resp_vec;
`endif

    logic [15:0] gold     = 16'h28AC;
    logic        fb_force = 1'b0;
    logic        fb_val   = 1'b0;
    logic [15:0] fb_mask  = 16'h0000;
    logic [3:0]  vec;

    assign vec     = {in1, in2, in3, in4};
    assign out1_fb = fb_force ? fb_val : (gold[vec] ^ fb_mask[vec]);

    always #5 clk = ~clk;

    part2_sweep_ctrl #(.EXPECTED(16'h28AC), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .out1_fb    (out1_fb),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail)
`ifdef SWEEP_CAPTURE_EN
        ,
        .resp_vec   (resp_vec)
`endif
    );

    typedef struct {
        logic        force_en;
        logic        force_val;
        logic [15:0] mask;
        int          err;
        int          ff;
        logic        pass;
    } vec_t;

    typedef struct {
        int          err;
        int          ff;
        logic        pass;
        logic [15:0] resp;
    } exp_t;

    vec_t tbl [8];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_fb(input vec_t r);
        fb_force = r.force_en;
        fb_val   = r.force_val;
        fb_mask  = r.mask;
    endtask

    task automatic push_exp(input vec_t r);
        exp_t e;
        e.err  = r.err;
        e.ff   = r.ff;
        e.pass = r.pass;
        e.resp = r.force_en ? {16{r.force_val}} : (gold ^ r.mask);
        sb.push_back(e);
    endtask

    // pulses start, optionally re-pulses it at cycle restart_at, scores the result at done
    task automatic run_sweep(input string tag, input int restart_at);
        exp_t e;
        int   lat;
        lat = -1;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= LAT + 20 && lat < 0; k++) begin
            @(posedge clk); #1 start = (k == restart_at);
            @(negedge clk);
            if (k == 1) check({tag, "_vec0"}, vec, 0);
            if (done) lat = k;
        end
        start = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, lat, LAT);
        if (lat < 0) return;
        check({tag, "_err_cnt"}, err_cnt, e.err);
        if (e.err != 0) check({tag, "_first_fail"}, first_fail, e.ff);
        check({tag, "_busy_fin"}, busy, 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_pass"}, pass, e.pass);
        check({tag, "_vec_hold"}, vec, 15);
`ifdef SWEEP_CAPTURE_EN
        check({tag, "_resp_vec"}, resp_vec, e.resp);
`endif
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        vec_t g;
        int   ndone;

        tbl[0] = '{1'b0, 1'b0, 16'h0000,  0,  0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 16'h0000,  6,  2, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h0000, 10,  0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'hFFFF, 16,  0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h0200,  1,  9, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 16'h8000,  1, 15, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'h0021,  2,  0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'h0840,  2,  6, 1'b0};
        g      = tbl[0];

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_fail", first_fail, 0);
        check("rst_vec", vec, 0);
`ifdef SWEEP_CAPTURE_EN
        check("rst_resp_vec", resp_vec, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_fb(tbl[i]);
            push_exp(tbl[i]);
            run_sweep($sformatf("tbl%0d", i), -1);
        end

        // restart attempt mid-sweep must not disturb the timing
        set_fb(g);
        push_exp(g);
        run_sweep("restart10", 10);

        // start with abort in IDLE is ignored
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("coincident_busy", busy, 0);
        check("coincident_pass_kept", pass, 1);

        // abort at cycle 20 with out1_fb tied low: vectors 0..5 compared
        set_fb(tbl[1]);
        @(posedge clk); #1 start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1 start = 1'b0;
            if (k == 20) abort = 1'b1;
        end
        @(negedge clk);
        check("abort_busy_c20", busy, 1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy_c21", busy, 0);
        check("abort_err_cnt", err_cnt, 3);
        check("abort_first_fail", first_fail, 2);
        check("abort_pass", pass, 0);
        count_done(60, ndone);
        check("abort_no_done", ndone, 0);
        check("abort_err_hold", err_cnt, 3);
        set_fb(g);
        push_exp(g);
        run_sweep("after_abort", -1);

        // reset at cycle 30 of a sweep with out1_fb tied low
        set_fb(tbl[1]);
        @(posedge clk); #1 start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_err_cnt", err_cnt, 4);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_first_fail", first_fail, 0);
        check("midrst_vec", vec, 0);
        check("midrst_pass", pass, 0);
        check("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        count_done(60, ndone);
        check("midrst_no_done", ndone, 0);
        set_fb(g);
        push_exp(g);
        run_sweep("after_rst", -1);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/part2_sweep_ctrl.md
PART2_SWEEP_CTRL -- requirements
Module: part2_sweep_ctrl

Interface
REQ-001 SHALL have parameter EXPECTED, 16'h28AC, golden truth table; bit i is the expected out1 for vector i = {in1,in2,in3,in4}.
REQ-002 SHALL have parameter SETTLE, 2, cycles each vector is held before sampling (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse to begin a sweep.
REQ-006 SHALL have port abort  input  1  level; terminates a sweep in progress.
REQ-007 SHALL have port out1_fb  input  1  out1 of the function under test.
REQ-008 SHALL have ports in1, in2, in3, in4  output  1 each  registered stimulus to the function under test.
REQ-009 SHALL have port busy  output  1  high while a sweep runs.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port err_cnt  output  5  mismatch count of the current or last sweep (0..16).
REQ-013 SHALL have port first_fail  output  4  index of first mismatching vector; valid when err_cnt != 0.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FINISH.
REQ-015 IDLE: start=1 and abort=0 -> DRIVE; vector index idx <= 0, err_cnt <= 0, pass <= 0, settle counter <= 0.
REQ-016 DRIVE: {in1,in2,in3,in4} = idx; settle counter increments each cycle; on reaching SETTLE-1 -> SAMPLE.
REQ-017 SAMPLE (one cycle): if out1_fb != EXPECTED[idx], err_cnt increments, and first_fail <= idx when err_cnt was 0.
REQ-018 SAMPLE: idx == 15 -> FINISH; else idx <= idx+1, settle counter <= 0, -> DRIVE.
REQ-019 FINISH (one cycle): done=1; pass <= (err_cnt after the final compare == 0); -> IDLE.
REQ-020 Sweep latency from start to done SHALL be exactly 16*(SETTLE+1)+1 cycles.
REQ-021 busy SHALL be 1 in DRIVE, SAMPLE and FINISH, and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored; start coincident with abort SHALL be ignored.
REQ-023 abort=1 in DRIVE or SAMPLE -> IDLE next cycle; no done pulse; pass=0; err_cnt and first_fail hold.
REQ-024 idx SHALL be 4 bits and SHALL not wrap; terminal index 15 is detected explicitly.
REQ-025 err_cnt SHALL be 5 bits so an all-fail sweep reports 16 without overflow.
REQ-026 Stimulus outputs SHALL hold their last value in IDLE and FINISH.

Reset
REQ-027 rst_n=0 SHALL force, immediately and asynchronously, state=IDLE, in1..in4=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, idx=0, settle counter=0.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep; no done pulse SHALL follow reset release.

Configuration
REQ-029 Macro SWEEP_CAPTURE_EN defined: SHALL add output resp_vec (16 bits), where bit idx is written with out1_fb in SAMPLE; cleared on start and on reset.
REQ-030 Macro SWEEP_CAPTURE_EN undefined: resp_vec port and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-031 Correct DUT, SETTLE=2: start pulse -> done at cycle 49, pass=1, err_cnt=0; resp_vec=16'h28AC when capture is enabled.
REQ-032 out1_fb tied 0: sweep -> err_cnt=6, first_fail=2, pass=0.
REQ-033 out1_fb tied 1: sweep -> err_cnt=10, first_fail=0, pass=0.
REQ-034 abort at cycle 20: busy=0 at cycle 21, no done pulse; a new start then completes normally with pass=1.
REQ-035 start pulsed again at cycle 10 of a sweep -> ignored, done still at cycle 49.
REQ-036 rst_n low at cycle 30 of a sweep -> all outputs 0 immediately; no done after release; next start sweeps from idx 0.
